// File: rtl/wb_hilo_stage_pkg.sv
// Shared widths, bus field offsets and stall-vector helpers for the write-back stage.
// The HI/LO read bypass is enabled by defining WB_HILO_BYPASS_EN.
package wb_hilo_stage_pkg;

  localparam int REG_W        = 32;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MTW_BUS_W    = MEM_TO_WB_WD + 64 + 1;
  localparam int RF_BUS_W     = 38;
  localparam int FWD_BUS_W    = 103;
  localparam int STALL_BUS    = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int WB_STALL_BIT  = 4;
  localparam int DS_STALL_BIT  = 5;

  localparam int WB_HILO_WE_BIT = 134;
  localparam int WB_HI_MSB      = 133;
  localparam int WB_HI_LSB      = 102;
  localparam int WB_LO_MSB      = 101;
  localparam int WB_LO_LSB      = 70;
  localparam int WB_PC_MSB      = 69;
  localparam int WB_PC_LSB      = 38;
  localparam int WB_RF_WE_BIT   = 37;
  localparam int WB_WADDR_MSB   = 36;
  localparam int WB_WADDR_LSB   = 32;
  localparam int WB_WDATA_MSB   = 31;
  localparam int WB_WDATA_LSB   = 0;

  typedef logic [STALL_BUS-1:0] stall_bus_t;

  // WB stops while the stage below keeps moving: a bubble must be inserted.
  function automatic logic stall_is_bubble(input stall_bus_t s);
    return (s[WB_STALL_BIT] == STOP) && (s[DS_STALL_BIT] == NO_STOP);
  endfunction

  function automatic logic stall_is_capture(input stall_bus_t s);
    return s[WB_STALL_BIT] == NO_STOP;
  endfunction

endpackage

// File: rtl/wb_hilo_stage_hilo_reg.sv
// HI/LO architectural register pair; hi_q/lo_q are the values presented to EX,
// bypassing the in-flight write when WB_HILO_BYPASS_EN is defined.
module hilo_reg
  import wb_hilo_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [REG_W-1:0] hi_in,
  input  logic [REG_W-1:0] lo_in,
  output logic [REG_W-1:0] hi_q,
  output logic [REG_W-1:0] lo_q
);

  logic [REG_W-1:0] hi_r;
  logic [REG_W-1:0] lo_r;

  // HI/LO state; a held WB re-applies the same write, which is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= {REG_W{1'b0}};
      lo_r <= {REG_W{1'b0}};
    end else if (we) begin
      hi_r <= hi_in;
      lo_r <= lo_in;
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

`ifdef WB_HILO_BYPASS_EN
  // Read port forwards the value being written this cycle.
  always_comb begin
    if (we) begin
      hi_q = hi_in;
      lo_q = lo_in;
    end else begin
      hi_q = hi_r;
      lo_q = lo_r;
    end
  end
`else
  // Read port shows committed state only; hazard logic covers the gap.
  always_comb begin
    hi_q = hi_r;
    lo_q = lo_r;
  end
`endif

endmodule

// File: rtl/wb_hilo_stage.sv
// MIPS write-back stage: stage register, regfile write port, HI/LO ownership, commit trace.
// Optional HI/LO read bypass via WB_HILO_BYPASS_EN.
module wb_hilo_stage
  import wb_hilo_stage_pkg::*;
#(
  parameter int MTW_W = MTW_BUS_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_BUS-1:0] stall,
  input  logic [MTW_W-1:0]     mem_to_wb_bus,
  output logic [RF_BUS_W-1:0]  wb_to_rf_bus,
  output logic [FWD_BUS_W-1:0] wb_to_id_forwarding,
  output logic [REG_W-1:0]     hi_o,
  output logic [REG_W-1:0]     lo_o,
  output logic [REG_W-1:0]     debug_wb_pc,
  output logic [3:0]           debug_wb_rf_wen,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [REG_W-1:0]     debug_wb_rf_wdata
);

  logic [MTW_W-1:0] wb_r;
  logic             hilo_we_s;
  logic [REG_W-1:0] hi_data_s;
  logic [REG_W-1:0] lo_data_s;
  logic [REG_W-1:0] pc_s;
  logic             rf_we_s;
  logic [4:0]       rf_waddr_s;
  logic [REG_W-1:0] rf_wdata_s;
  logic             unused_stall_s;

  assign unused_stall_s = ^stall[3:0];

  // Stage register: bubble beats capture, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_r <= {MTW_W{1'b0}};
    end else if (stall_is_bubble(stall)) begin
      wb_r <= {MTW_W{1'b0}};
    end else if (stall_is_capture(stall)) begin
      wb_r <= mem_to_wb_bus;
    end else begin
      wb_r <= wb_r;
    end
  end

  assign hilo_we_s  = wb_r[WB_HILO_WE_BIT];
  assign hi_data_s  = wb_r[WB_HI_MSB:WB_HI_LSB];
  assign lo_data_s  = wb_r[WB_LO_MSB:WB_LO_LSB];
  assign pc_s       = wb_r[WB_PC_MSB:WB_PC_LSB];
  assign rf_we_s    = wb_r[WB_RF_WE_BIT];
  assign rf_waddr_s = wb_r[WB_WADDR_MSB:WB_WADDR_LSB];
  assign rf_wdata_s = wb_r[WB_WDATA_MSB:WB_WDATA_LSB];

  // $0 writes are passed through; the regfile discards them.
  assign wb_to_rf_bus        = {rf_we_s, rf_waddr_s, rf_wdata_s};
  assign wb_to_id_forwarding = {hilo_we_s, hi_data_s, lo_data_s, rf_we_s, rf_waddr_s, rf_wdata_s};

  assign debug_wb_pc       = pc_s;
  assign debug_wb_rf_wen   = {4{rf_we_s}};
  assign debug_wb_rf_wnum  = rf_waddr_s;
  assign debug_wb_rf_wdata = rf_wdata_s;

  hilo_reg u_hilo_reg (
    .clk   (clk),
    .rst   (rst),
    .we    (hilo_we_s),
    .hi_in (hi_data_s),
    .lo_in (lo_data_s),
    .hi_q  (hi_o),
    .lo_q  (lo_o)
  );

endmodule

// File: tb/tb_wb_hilo_stage.sv
// Self-checking bench for wb_hilo_stage: transaction-level model plus directed literal checks.
module tb_wb_hilo_stage;

  typedef struct {
    bit        hilo_we;
    bit [31:0] hi;
    bit [31:0] lo;
    bit [31:0] pc;
    bit        rf_we;
    bit [4:0]  waddr;
    bit [31:0] wdata;
  } rec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [134:0] mem_to_wb_bus;
  logic [37:0]  wb_to_rf_bus;
  logic [102:0] wb_to_id_forwarding;
  logic [31:0]  hi_o, lo_o, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]   debug_wb_rf_wen;
  logic [4:0]   debug_wb_rf_wnum;

  int   n_cmp = 0;
  int   n_bad = 0;
  rec_t cur_in, m_stage;
  bit [31:0] m_hi, m_lo;

  wb_hilo_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall               (stall),
    .mem_to_wb_bus       (mem_to_wb_bus),
    .wb_to_rf_bus        (wb_to_rf_bus),
    .wb_to_id_forwarding (wb_to_id_forwarding),
    .hi_o                (hi_o),
    .lo_o                (lo_o),
    .debug_wb_pc         (debug_wb_pc),
    .debug_wb_rf_wen     (debug_wb_rf_wen),
    .debug_wb_rf_wnum    (debug_wb_rf_wnum),
    .debug_wb_rf_wdata   (debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  function automatic rec_t mk(bit hw, bit [31:0] hi, bit [31:0] lo, bit [31:0] pc,
                              bit we, bit [4:0] wa, bit [31:0] wd);
    rec_t r;
    r.hilo_we = hw; r.hi = hi; r.lo = lo; r.pc = pc;
    r.rf_we = we; r.waddr = wa; r.wdata = wd;
    return r;
  endfunction

  task automatic drive(input rec_t r);
    cur_in = r;
    mem_to_wb_bus = {r.hilo_we, r.hi, r.lo, r.pc, r.rf_we, r.waddr, r.wdata};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: what WB holds and what HI/LO contain after each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_stage = mk(0, 0, 0, 0, 0, 0, 0);
      m_hi = 0;
      m_lo = 0;
    end else begin
      if (m_stage.hilo_we) begin
        m_hi = m_stage.hi;
        m_lo = m_stage.lo;
      end
      if (stall[4] && !stall[5]) m_stage = mk(0, 0, 0, 0, 0, 0, 0);
      else if (!stall[4])        m_stage = cur_in;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    bit [31:0] e_hi, e_lo;
`ifdef WB_HILO_BYPASS_EN
    e_hi = m_stage.hilo_we ? m_stage.hi : m_hi;
    e_lo = m_stage.hilo_we ? m_stage.lo : m_lo;
`else
    e_hi = m_hi;
    e_lo = m_lo;
`endif
    check("m_rf",    128'(wb_to_rf_bus), 128'({m_stage.rf_we, m_stage.waddr, m_stage.wdata}));
    check("m_fwd",   128'(wb_to_id_forwarding),
          128'({m_stage.hilo_we, m_stage.hi, m_stage.lo, m_stage.rf_we, m_stage.waddr, m_stage.wdata}));
    check("m_hi",    128'(hi_o), 128'(e_hi));
    check("m_lo",    128'(lo_o), 128'(e_lo));
    check("m_pc",    128'(debug_wb_pc), 128'(m_stage.pc));
    check("m_wen",   128'(debug_wb_rf_wen), 128'({4{m_stage.rf_we}}));
    check("m_wnum",  128'(debug_wb_rf_wnum), 128'(m_stage.waddr));
    check("m_wdata", 128'(debug_wb_rf_wdata), 128'(m_stage.wdata));
  end

  initial begin
    rst = 1'b1;
    stall = 6'b000000;
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    check("rst_rf", 128'(wb_to_rf_bus), 128'(38'h0));
    check("rst_hi", 128'(hi_o), 128'(32'h0));
    rst = 1'b0;

    // ALU commit
    drive(mk(0, 0, 0, 32'hBFC00010, 1, 5'd8, 32'h1234));
    @(negedge clk);
    check("alu_rf",  128'(wb_to_rf_bus), 128'({1'b1, 5'd8, 32'h1234}));
    check("alu_wen", 128'(debug_wb_rf_wen), 128'(4'hF));
    check("alu_pc",  128'(debug_wb_pc), 128'(32'hBFC00010));

    // HI/LO write
    drive(mk(1, 32'hDEAD0000, 32'h0000BEEF, 32'hBFC00014, 0, 0, 0));
    @(negedge clk);
`ifdef WB_HILO_BYPASS_EN
    check("hilo_same_hi", 128'(hi_o), 128'(32'hDEAD0000));
`else
    check("hilo_same_hi", 128'(hi_o), 128'(32'h0));
`endif
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("hilo_next_hi", 128'(hi_o), 128'(32'hDEAD0000));
    check("hilo_next_lo", 128'(lo_o), 128'(32'h0000BEEF));

    // Bubble with hilo_we on the input
    stall = 6'b010000;
    drive(mk(1, 32'h11111111, 32'h22222222, 32'hBFC00018, 1, 5'd3, 32'h77));
    @(negedge clk);
    check("bub_wen", 128'(debug_wb_rf_wen), 128'(4'h0));
    check("bub_fwd", 128'(wb_to_id_forwarding), 128'(103'h0));
    @(negedge clk);
    check("bub_hi", 128'(hi_o), 128'(32'hDEAD0000));
    check("bub_lo", 128'(lo_o), 128'(32'h0000BEEF));

    // Hold for 3 cycles after loading a HI/LO + regfile writer
    stall = 6'b000000;
    drive(mk(1, 32'hAAAA0001, 32'hAAAA0002, 32'hBFC00020, 1, 5'd9, 32'h5555));
    @(negedge clk);
    stall = 6'b110000;
    for (int i = 0; i < 3; i++) begin
      drive(mk(1, 32'h0BAD0000 + i, 32'h0BAD1000 + i, 32'hBFC00100 + 4 * i, 1, 5'(i + 1), i));
      @(negedge clk);
      check("hold_pc",    128'(debug_wb_pc), 128'(32'hBFC00020));
      check("hold_wdata", 128'(debug_wb_rf_wdata), 128'(32'h5555));
      check("hold_hi",    128'(hi_o), 128'(32'hAAAA0001));
      check("hold_lo",    128'(lo_o), 128'(32'hAAAA0002));
    end

    // Back-to-back mult then div
    stall = 6'b000000;
    drive(mk(1, 32'h3, 32'h4, 32'hBFC00030, 0, 0, 0));
    @(negedge clk);
`ifdef WB_HILO_BYPASS_EN
    check("b2b_first_hi", 128'(hi_o), 128'(32'h3));
`else
    check("b2b_first_hi", 128'(hi_o), 128'(32'hAAAA0001));
`endif
    drive(mk(1, 32'h7, 32'h8, 32'hBFC00034, 0, 0, 0));
    @(negedge clk);
`ifdef WB_HILO_BYPASS_EN
    check("b2b_mid_hi", 128'(hi_o), 128'(32'h7));
`else
    check("b2b_mid_hi", 128'(hi_o), 128'(32'h3));
    check("b2b_mid_lo", 128'(lo_o), 128'(32'h4));
`endif
    drive(mk(0, 0, 0, 32'hBFC00038, 0, 0, 0));
    @(negedge clk);
    check("b2b_end_hi", 128'(hi_o), 128'(32'h7));
    check("b2b_end_lo", 128'(lo_o), 128'(32'h8));

    // Write to $0 passes through
    drive(mk(0, 0, 0, 32'hBFC00040, 1, 5'd0, 32'hFFFF));
    @(negedge clk);
    check("r0_rf", 128'(wb_to_rf_bus), 128'({1'b1, 5'd0, 32'hFFFF}));

    // Asynchronous reset mid-cycle with a pending HI/LO write in WB
    drive(mk(1, 32'h12345678, 32'h9ABCDEF0, 32'hBFC00044, 1, 5'd10, 32'h42));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_rf",  128'(wb_to_rf_bus), 128'(38'h0));
    check("arst_fwd", 128'(wb_to_id_forwarding), 128'(103'h0));
    check("arst_pc",  128'(debug_wb_pc), 128'(32'h0));
    check("arst_hi",  128'(hi_o), 128'(32'h0));
    check("arst_lo",  128'(lo_o), 128'(32'h0));
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_lost_hi", 128'(hi_o), 128'(32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_hilo_stage.md
# wb_hilo_stage

Write-back stage of the 5-stage MIPS pipeline, directly downstream of the memory stage. It registers the memory-to-write-back bus under stall control and drives the register-file write port. It owns the HI/LO architectural register pair written by multiply/divide results, and returns forwarding data to ID, HI/LO read data to EX, and the debug commit trace.

## Interface
- `MTW_W`, 135: width of incoming bus (`MEM_TO_WB_WD` + 64 + 1).
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  `StallBus` (6)  stall vector; bit 4 = WB hold, bit 5 = downstream hold; `Stop`=1.
- `mem_to_wb_bus`  in  135  [134] hilo_we, [133:102] hi_data, [101:70] lo_data, [69:38] pc, [37] rf_we, [36:32] rf_waddr, [31:0] rf_wdata.
- `wb_to_rf_bus`  out  38  {rf_we, rf_waddr, rf_wdata} to regfile write port.
- `wb_to_id_forwarding`  out  103  {hilo_we, hi_data, lo_data, rf_we, rf_waddr, rf_wdata}.
- `hi_o`, `lo_o`  out  32 each  HI/LO read values to EX.
- `debug_wb_pc`  out  32  committing PC.
- `debug_wb_rf_wen`  out  4  byte-enable of trace write.
- `debug_wb_rf_wnum`  out  5  trace destination.
- `debug_wb_rf_wdata`  out  32  trace data.

## Operation
- Pipeline register `wb_r` (135 b), priority order:
  - `rst` → all zero (async).
  - `stall[4]==Stop && stall[5]==NoStop` → zero (bubble).
  - `stall[4]==NoStop` → capture `mem_to_wb_bus`.
  - else → hold.
- Unpack `wb_r` per bus layout above; all outputs derive from `wb_r` and HI/LO state.
- Regfile write: `wb_to_rf_bus` = {rf_we, rf_waddr, rf_wdata} unmodified. Writes to $0 pass through; the regfile ignores them.
- HI/LO: 32-bit registers `hi_q`, `lo_q`, async reset to 0.
  - At every posedge with `wb_r` hilo_we=1: `hi_q`←hi_data, `lo_q`←lo_data.
  - While WB holds, the same write repeats, which is idempotent.
  - Bubbles have hilo_we=0 and never write.
- Debug trace:
  - `debug_wb_pc` = pc.
  - `debug_wb_rf_wen` = {4{rf_we}}.
  - `debug_wb_rf_wnum` = rf_waddr.
  - `debug_wb_rf_wdata` = rf_wdata.
- Forwarding bus is purely combinational from `wb_r`.

## Timing
- Latency: bus value at posedge N is visible on all outputs after N. Regfile write commits at N+1. HI/LO update at N+1.
- Reset value of every output is 0: all of `wb_r`, `hi_q` and `lo_q` are zero.
- Reset mid-operation clears `wb_r` and HI/LO immediately and asynchronously. Any pending HI/LO write is lost.
- Simultaneous bubble insert and hilo_we on the input: the bubble wins and no write happens.
- Back-to-back hilo_we instructions: each overwrites in order. `hi_o`/`lo_o` per Configuration.

## Configuration
- `WB_HILO_BYPASS_EN` defined:
  - `hi_o` = hilo_we ? hi_data : `hi_q` (same for lo), muxed combinationally from `wb_r`.
  - EX sees a result that is being written in the same cycle.
- Not defined:
  - `hi_o`/`lo_o` = `hi_q`/`lo_q` only.
  - Hazard control must stall `mfhi`/`mflo` one extra cycle behind a WB-resident hilo_we.

## Structure
- `lib/defines.vh` holds `MEM_TO_WB_WD`, `StallBus`, `Stop`/`NoStop`, and new field offsets `WB_HILO_WE_BIT`, `WB_HI_MSB/LSB`, `WB_LO_MSB/LSB`.
- One sub-module, `hilo_reg`:
  - Inputs: clk, rst, we, hi_in, lo_in.
  - Outputs: hi_q, lo_q.
  - Contains the bypass mux under the macro.

## Test plan
- Reset: assert `rst` mid-cycle with `wb_r` loaded → all outputs 0 immediately, `hi_o`=`lo_o`=0.
- Normal ALU commit: bus pc=0xBFC00010, rf_we=1, waddr=8, wdata=0x1234, stall=0 → next cycle `wb_to_rf_bus`={1,8,0x1234}, `debug_wb_rf_wen`=4'hF.
- HI/LO write: hilo_we=1, hi=0xDEAD0000, lo=0x0000BEEF → `hi_q`/`lo_q` hold those values one cycle later.
  - With bypass: `hi_o`=0xDEAD0000 in the same cycle.
  - Without bypass: `hi_o`=0xDEAD0000 one cycle later.
- Bubble: stall=6'b010000 with hilo_we=1 on input → `wb_r`=0, HI/LO unchanged, `debug_wb_rf_wen`=0.
- Hold: stall=6'b110000 for 3 cycles → outputs frozen, input changes ignored, HI/LO value stable.
- Back-to-back: mult then div with hilo_we both → HI/LO end with the div values. The intermediate cycle shows the mult values.
